// File: rtl/RV32I_definitions.sv
// Shared RV32I fetch-path types and constants.
package RV32I_definitions;

  localparam logic [31:0] RV32I_NOP = 32'h00000013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        fault;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Fetch-entry FIFO with synchronous clear; pointers wrap modulo BUF_DEPTH.
module fetch_fifo
  import RV32I_definitions::*;
#(
  parameter int unsigned BUF_DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(BUF_DEPTH),
  localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  fetch_entry_t     push_entry,
  output logic [CNT_W-1:0] count,
  output fetch_entry_t     head
);

  fetch_entry_t     mem [BUF_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Clear has priority over any simultaneous push or pop.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge Clk) begin
    if (push && !clear) mem[wr_ptr] <= push_entry;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/if_fetch_responder.sv
// Instruction-fetch responder: PC handshake, 1-cycle IMEM read, buffered delivery to ID.
// Optional macro FETCH_BOUNDS_CHECK_EN turns out-of-range fetches into faulting NOP entries.
module if_fetch_responder
  import RV32I_definitions::*;
#(
  parameter int unsigned IMEM_ADDR_WIDTH = 10,
  parameter int unsigned BUF_DEPTH       = 4
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic [31:0]                PC_In,
  input  logic                       PC_Valid,
  output logic                       PC_Ready,
  input  logic                       Flush,
  output logic                       IMEM_Rd_En,
  output logic [IMEM_ADDR_WIDTH-1:0] IMEM_Addr,
  input  logic [31:0]                IMEM_Data,
  output logic                       ID_Valid,
  input  logic                       ID_Ready,
  output logic [31:0]                ID_Instr,
  output logic [31:0]                ID_PC,
  output logic                       ID_Fetch_Fault
);

  localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int unsigned OCC_W = CNT_W + 1;

  logic [CNT_W-1:0] fifo_count;
  logic [OCC_W-1:0] occ;
  fetch_entry_t     head;
  fetch_entry_t     push_entry;
  logic             inflight_valid;
  logic [31:0]      inflight_pc;
  logic             inflight_fault;
  logic             accept;
  logic             push;
  logic             pop;
  logic             pc_fault;

`ifdef FETCH_BOUNDS_CHECK_EN
  logic unused_pc_bits;
  assign pc_fault       = |PC_In[31:IMEM_ADDR_WIDTH+2];
  assign unused_pc_bits = ^PC_In[1:0];
`else
  logic unused_pc_bits;
  assign pc_fault       = 1'b0;
  assign unused_pc_bits = ^{PC_In[31:IMEM_ADDR_WIDTH+2], PC_In[1:0]};
`endif

  // Occupancy counts the in-flight read so every accepted fetch owns a FIFO slot.
  assign occ        = OCC_W'(fifo_count) + OCC_W'(inflight_valid);
  assign PC_Ready   = !Reset && !Flush && (occ < OCC_W'(BUF_DEPTH));
  assign accept     = PC_Valid && PC_Ready;
  assign IMEM_Rd_En = accept && !pc_fault;
  assign IMEM_Addr  = PC_In[IMEM_ADDR_WIDTH+1:2];

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      inflight_valid <= 1'b0;
      inflight_pc    <= '0;
      inflight_fault <= 1'b0;
    end else begin
      inflight_valid <= accept;
      if (accept) begin
        inflight_pc    <= PC_In;
        inflight_fault <= pc_fault;
      end
    end
  end

  // A flush drops the read returning this cycle along with everything queued.
  assign push = inflight_valid && !Flush;
  assign pop  = ID_Valid && ID_Ready && !Flush;

  assign push_entry = '{instr: inflight_fault ? RV32I_NOP : IMEM_Data,
                        pc:    inflight_pc,
                        fault: inflight_fault};

  fetch_fifo #(
    .BUF_DEPTH(BUF_DEPTH)
  ) u_fetch_fifo (
    .Clk       (Clk),
    .Reset     (Reset),
    .push      (push),
    .pop       (pop),
    .clear     (Flush),
    .push_entry(push_entry),
    .count     (fifo_count),
    .head      (head)
  );

  assign ID_Valid       = (fifo_count != '0);
  assign ID_Instr       = ID_Valid ? head.instr : RV32I_NOP;
  assign ID_PC          = ID_Valid ? head.pc : 32'h0;
  assign ID_Fetch_Fault = ID_Valid && head.fault;

endmodule

// File: tb/tb_if_fetch_responder.sv
// Randomized bench for if_fetch_responder against a queue-based reference model.
module tb_if_fetch_responder;

  localparam int unsigned AW    = 10;
  localparam int unsigned DEPTH = 4;

  logic          Clk = 1'b0;
  logic          Reset;
  logic [31:0]   PC_In;
  logic          PC_Valid;
  logic          PC_Ready;
  logic          Flush;
  logic          IMEM_Rd_En;
  logic [AW-1:0] IMEM_Addr;
  logic [31:0]   IMEM_Data;
  logic          ID_Valid;
  logic          ID_Ready;
  logic [31:0]   ID_Instr;
  logic [31:0]   ID_PC;
  logic          ID_Fetch_Fault;

  always #5 Clk = ~Clk;

  if_fetch_responder #(
    .IMEM_ADDR_WIDTH(AW),
    .BUF_DEPTH      (DEPTH)
  ) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .PC_In         (PC_In),
    .PC_Valid      (PC_Valid),
    .PC_Ready      (PC_Ready),
    .Flush         (Flush),
    .IMEM_Rd_En    (IMEM_Rd_En),
    .IMEM_Addr     (IMEM_Addr),
    .IMEM_Data     (IMEM_Data),
    .ID_Valid      (ID_Valid),
    .ID_Ready      (ID_Ready),
    .ID_Instr      (ID_Instr),
    .ID_PC         (ID_PC),
    .ID_Fetch_Fault(ID_Fetch_Fault)
  );

  // IMEM: word n holds 0x1000+n, one-cycle latency, junk when not read.
  always @(posedge Clk) begin
    if (IMEM_Rd_En) IMEM_Data <= 32'h1000 + 32'(IMEM_Addr);
    else            IMEM_Data <= $urandom;
  end

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        fault;
  } exp_t;

  exp_t q[$];
  exp_t pend;
  int   pend_v;
  int   checks;
  int   errors;
  int   n_acc;
  bit   last_acc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t make_entry(input logic [31:0] pc);
    exp_t e;
    logic [31:0] word;
    word    = {22'h0, pc[AW+1:2]};
    e.pc    = pc;
`ifdef FETCH_BOUNDS_CHECK_EN
    e.fault = (pc[31:AW+2] != '0);
`else
    e.fault = 1'b0;
`endif
    e.instr = e.fault ? 32'h00000013 : 32'h1000 + word;
    return e;
  endfunction

  // One clock: drive at posedge+1, check before the next edge, then advance the model.
  task automatic cycle(input logic pv, input logic [31:0] pc, input logic idr, input logic fl);
    bit   exp_ready;
    bit   acc;
    bit   pop;
    exp_t e;
    PC_Valid = pv;
    PC_In    = pc;
    ID_Ready = idr;
    Flush    = fl;
    #3;
    exp_ready = !fl && ((q.size() + pend_v) < DEPTH);
    acc       = pv && exp_ready;
    e         = make_entry(pc);
    check("pc_ready", PC_Ready, exp_ready);
    check("imem_rd_en", IMEM_Rd_En, acc && !e.fault);
    if (acc && !e.fault) check("imem_addr", IMEM_Addr, pc[AW+1:2]);
    check("id_valid", ID_Valid, q.size() != 0);
    if (q.size() != 0) begin
      check("id_pc", ID_PC, q[0].pc);
      check("id_instr", ID_Instr, q[0].instr);
      check("id_fault", ID_Fetch_Fault, q[0].fault);
    end else begin
      check("empty_pc", ID_PC, 32'h0);
      check("empty_instr", ID_Instr, 32'h00000013);
      check("empty_fault", ID_Fetch_Fault, 1'b0);
    end
    pop      = (q.size() != 0) && idr;
    last_acc = acc;
    if (acc) n_acc++;
    @(posedge Clk);
    if (fl) begin
      q.delete();
      pend_v = 0;
    end else begin
      if (pop) void'(q.pop_front());
      if (pend_v != 0) q.push_back(pend);
      pend_v = acc ? 1 : 0;
      pend   = e;
    end
    #1;
  endtask

  initial begin
    logic [31:0] pc;
    int          a0;
    checks   = 0;
    errors   = 0;
    n_acc    = 0;
    pend_v   = 0;
    Reset    = 1'b1;
    PC_Valid = 1'b1;
    PC_In    = 32'h4;
    ID_Ready = 1'b1;
    Flush    = 1'b0;
    repeat (2) @(posedge Clk);
    #3;
    check("reset_id_valid", ID_Valid, 1'b0);
    check("reset_pc_ready", PC_Ready, 1'b0);
    check("reset_rd_en", IMEM_Rd_En, 1'b0);
    check("reset_instr", ID_Instr, 32'h00000013);
    check("reset_pc", ID_PC, 32'h0);
    check("reset_fault", ID_Fetch_Fault, 1'b0);
    @(posedge Clk);
    #1 Reset = 1'b0;

    // Streaming with ID always ready: one fetch per cycle.
    pc = 32'h0;
    a0 = n_acc;
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, pc, 1'b1, 1'b0);
      if (last_acc) pc += 4;
    end
    check("stream_accepts", 32'(n_acc - a0), 32'd12);
    repeat (3) cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // Back-pressure: exactly DEPTH accepts, then drain in order.
    a0 = n_acc;
    pc = 32'h40;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, pc, 1'b0, 1'b0);
      if (last_acc) pc += 4;
    end
    check("stall_accepts", 32'(n_acc - a0), 32'(DEPTH));
    check("stall_ready_low", PC_Ready, 1'b0);
    repeat (6) cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // Flush the cycle after accepting 0x20 with two entries queued.
    cycle(1'b1, 32'h8, 1'b0, 1'b0);
    cycle(1'b1, 32'hC, 1'b0, 1'b0);
    cycle(1'b1, 32'h20, 1'b0, 1'b0);
    cycle(1'b1, 32'h30, 1'b0, 1'b1);
    check("flush_id_valid", ID_Valid, 1'b0);
    cycle(1'b1, 32'h100, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    check("redirect_pc", ID_PC, 32'h100);
    repeat (2) cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // Flush coinciding with pop and a valid PC.
    cycle(1'b1, 32'h50, 1'b0, 1'b0);
    cycle(1'b1, 32'h54, 1'b0, 1'b0);
    cycle(1'b1, 32'h58, 1'b1, 1'b1);
    check("flush_pop_empty", ID_Valid, 1'b0);
    repeat (2) cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // Asynchronous reset pulse mid-stream.
    pc = 32'h200;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, pc, 1'b0, 1'b0);
      if (last_acc) pc += 4;
    end
    PC_Valid = 1'b1;
    #2 Reset = 1'b1;
    #1;
    check("async_id_valid", ID_Valid, 1'b0);
    check("async_pc_ready", PC_Ready, 1'b0);
    check("async_rd_en", IMEM_Rd_En, 1'b0);
    q.delete();
    pend_v = 0;
    @(posedge Clk);
    #1 Reset = 1'b0;
    pc = 32'h300;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, pc, 1'b1, 1'b0);
      if (last_acc) pc += 4;
    end

    // Out-of-range fetch (faults when bounds checking is built in, aliases otherwise).
    cycle(1'b1, 32'h00001000, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      pc = {20'h0, 10'($urandom_range(0, 1023)), 2'($urandom)};
      if ($urandom_range(0, 7) == 0) pc[31:12] = 20'($urandom);
      cycle($urandom_range(0, 3) != 0, pc, $urandom_range(0, 3) != 0,
            $urandom_range(0, 15) == 0);
    end
    repeat (6) cycle(1'b0, 32'h0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
